fixed_multiplier: RTL and testbench
===================================

// Module: fixed_multiplier
// PURPOSE
//   Sequential signed fixed-point multiplier (shift-add, radix-2), the multiply counterpart of the divider in src/Math.
//   Takes two Q(WIDTH-Q_BITS-1).Q_BITS operands (Q3.12 default) and returns a rounded Q-format product.
//   Uses the same start/ready/valid handshake as the divider, so shading/raster datapaths can swap units.
//   Fixed latency; one operation in flight.
// PARAMETERS
//   WIDTH   `WIDTH (16)   operand/result width, two's complement
//   Q_BITS  `Q_BITS (12)  fractional bits
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high
//   start        in   1      request; sampled only while ready=1
//   multiplicand in   WIDTH  signed Q operand A
//   multiplier   in   WIDTH  signed Q operand B
//   valid        out  1      product/overflow valid, one-cycle pulse
//   ready        out  1      idle, able to accept start
//   overflow     out  1      rounded result not representable; qualified by valid
//   product      out  WIDTH  signed Q result, held until next accepted start
// BEHAVIOUR
//   Reset: valid=0, ready=1, overflow=0, product=0, state=IDLE, counter=0. Reset mid-operation aborts; nothing is emitted.
//   FSM: IDLE -> RUN (WIDTH cycles) -> FINISH (1 cycle) -> IDLE.
//   IDLE:
//     - If start&&ready: latch |A|, |B| as WIDTH-bit unsigned; sign = A[MSB]^B[MSB].
//     - Clear 2*WIDTH-bit accumulator; ready<=0; valid<=0.
//     - |MIN| = 2^(WIDTH-1) must be handled correctly as an unsigned magnitude.
//   RUN, per cycle:
//     - If mult_reg[0]: acc += mcand_reg.
//     - mcand_reg <<= 1; mult_reg >>= 1; cnt++.
//     - Leave RUN when cnt==WIDTH-1. No early exit on zero operands.
//   FINISH:
//     - Rounding: mag = (acc + 2^(Q_BITS-1)) >> Q_BITS, i.e. round half away from zero.
//     - Overflow: sign=0 && mag>2^(WIDTH-1)-1, or sign=1 && mag>2^(WIDTH-1).
//     - Result: product = sign ? -mag : mag, subject to CONFIGURATION.
//     - Handshake: valid<=1, ready<=1 on the same edge; return to IDLE.
//   Latency: valid rises WIDTH+1 edges after the edge that samples start (17 for WIDTH=16).
//   Throughput: one result per WIDTH+2 cycles.
//   valid lasts exactly one cycle unless a new start is accepted.
//   start while ready=0 is ignored; the operation in progress is unaffected.
//   start in the valid cycle is accepted (ready=1). valid drops next edge; product holds until the new FINISH.
//   A zero operand still takes full latency; product=0, overflow=0.
//   Operands are sampled only on the accepting edge; later input changes have no effect.
// CONFIGURATION
//   FIXED_MUL_SATURATE_EN defined:
//     - On overflow, product clamps to `MAX_16 (0x7FFF) if sign=0, else `MIN_16 (0x8000).
//     - overflow=1.
//   FIXED_MUL_SATURATE_EN undefined:
//     - product = low WIDTH bits of the signed rounded result (wrap).
//     - overflow still reported.
// STRUCTURE
//   Shared package (fixed_pkg):
//     - typedef logic signed [WIDTH-1:0] fixed_t
//     - FX_MAX, FX_MIN, FX_ONE (1<<Q_BITS)
//     - typedef enum {MUL_IDLE, MUL_RUN, MUL_FINISH} mul_state_t
//   Sub-module fx_round_sat (combinational): acc + sign -> product, overflow.
//     - Holds the rounding and saturation/wrap logic.
//     - Reused later by the divider output stage.
// TESTING (Q3.12, WIDTH=16)
//   1. 0x1800*0x2000 (1.5*2.0) -> product 0x3000, overflow 0, valid exactly 17 edges after start.
//   2. 0xE800*0x2000 (-1.5*2.0) -> 0xD000; 0xE800*0xE000 -> 0x3000.
//   3. 0x4000*0x4000 (4*4) -> overflow 1.
//        With FIXED_MUL_SATURATE_EN: 0x7FFF; negate A -> 0x8000.
//        Without: wrap result 0x0000.
//   4. 0x8000*0x1000 (-8*1) -> 0x8000, overflow 0.
//      0x8000*0xF000 (-8*-1) -> overflow 1 (saturate 0x7FFF).
//   5. Rounding:
//        0x0001*0x0800 -> 0x0001
//        0xFFFF*0x0800 -> 0xFFFF
//        0x0001*0x07FF -> 0x0000
//   6. Handshake:
//        start pulsed again mid-RUN with new operands -> ignored, original result returned.
//        reset at RUN cycle 5 -> ready=1, valid never pulses.
//        back-to-back start in the valid cycle -> second result correct.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions (Q3.12 by default) used by the multiplier and its rounding stage.
package fixed_pkg;

  localparam int FX_WIDTH  = 16;
  localparam int FX_Q_BITS = 12;

  typedef logic signed [FX_WIDTH-1:0] fixed_t;

  localparam fixed_t FX_MAX = {1'b0, {(FX_WIDTH-1){1'b1}}};
  localparam fixed_t FX_MIN = {1'b1, {(FX_WIDTH-1){1'b0}}};
  localparam fixed_t FX_ONE = fixed_t'(1) << FX_Q_BITS;

  typedef enum logic [1:0] {
    MUL_IDLE   = 2'd0,
    MUL_RUN    = 2'd1,
    MUL_FINISH = 2'd2
  } mul_state_t;

endpackage

// File: rtl/fixed_multiplier_if.sv
// Start/ready/valid bus shared by the fixed-point arithmetic units.
// Handshake: start is taken only on an edge where ready=1; valid is a one-cycle
// pulse that qualifies product/overflow; product holds until the next accepted start.
interface fixed_multiplier_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             valid;
    logic             ready;
    logic             overflow;
    logic [WIDTH-1:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  valid, ready, overflow, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output valid, ready, overflow, product
    );
endinterface

// File: rtl/fx_round_sat.sv
// Rounds an unsigned 2*WIDTH-bit Q product magnitude half-away-from-zero, applies the sign,
// and flags overflow. Saturates when FIXED_MUL_SATURATE_EN is defined, otherwise wraps.
module fx_round_sat #(
    parameter int WIDTH  = 16,
    parameter int Q_BITS = 12
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic               sign,
    output logic [WIDTH-1:0]   product,
    output logic               overflow
);
    localparam int MW = 2*WIDTH - Q_BITS;
    localparam logic [2*WIDTH-1:0] HALF    = (2*WIDTH)'(1) << (Q_BITS-1);
    localparam logic [MW-1:0]      POS_LIM = MW'((64'd1 << (WIDTH-1)) - 64'd1);
    localparam logic [MW-1:0]      NEG_LIM = MW'(64'd1 << (WIDTH-1));

    logic [2*WIDTH-1:0] rounded;
    logic [MW-1:0]      mag;
    logic [MW-1:0]      signed_res;

    always_comb begin
        rounded    = acc + HALF;
        mag        = rounded[2*WIDTH-1:Q_BITS];
        signed_res = sign ? -mag : mag;
        overflow   = sign ? (mag > NEG_LIM) : (mag > POS_LIM);
`ifdef FIXED_MUL_SATURATE_EN
        if (overflow)
            product = sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            product = signed_res[WIDTH-1:0];
`else
        product = signed_res[WIDTH-1:0];
`endif
    end
endmodule

// File: rtl/fixed_multiplier.sv
// Sequential signed Q-format shift-add multiplier, fixed latency WIDTH+1 edges, one op in flight.
// Optional saturation on overflow is enabled by defining FIXED_MUL_SATURATE_EN.
module fixed_multiplier
    import fixed_pkg::*;
#(
    parameter int WIDTH  = FX_WIDTH,
    parameter int Q_BITS = FX_Q_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    fixed_multiplier_if.slave        bus,
    output mul_state_t               dbg_state,
    output logic [$clog2(WIDTH)-1:0] dbg_cnt
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

    mul_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mult_q, mult_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 sign_q, sign_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;
    logic                 overflow_q, overflow_d;
    logic [WIDTH-1:0]     product_q, product_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH-1:0]     rs_product;
    logic                 rs_overflow;

    // Magnitudes are unsigned WIDTH bits, so -MIN lands on 2^(WIDTH-1) exactly.
    assign a_mag = bus.multiplicand[WIDTH-1] ? -bus.multiplicand : bus.multiplicand;
    assign b_mag = bus.multiplier[WIDTH-1]   ? -bus.multiplier   : bus.multiplier;

    fx_round_sat #(.WIDTH(WIDTH), .Q_BITS(Q_BITS)) u_round_sat (
        .acc      (acc_q),
        .sign     (sign_q),
        .product  (rs_product),
        .overflow (rs_overflow)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mult_d     = mult_q;
        acc_d      = acc_q;
        sign_d     = sign_q;
        valid_d    = 1'b0;
        ready_d    = ready_q;
        overflow_d = overflow_q;
        product_d  = product_q;
        case (state_q)
            MUL_IDLE: begin
                if (bus.start && ready_q) begin
                    mcand_d = {{WIDTH{1'b0}}, a_mag};
                    mult_d  = b_mag;
                    sign_d  = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = MUL_RUN;
                end
            end
            MUL_RUN: begin
                if (mult_q[0]) acc_d = acc_q + mcand_q;
                mcand_d = mcand_q << 1;
                mult_d  = mult_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = MUL_FINISH;
            end
            MUL_FINISH: begin
                valid_d    = 1'b1;
                ready_d    = 1'b1;
                product_d  = rs_product;
                overflow_d = rs_overflow;
                state_d    = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MUL_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mult_q     <= '0;
            acc_q      <= '0;
            sign_q     <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
            product_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mult_q     <= mult_d;
            acc_q      <= acc_d;
            sign_q     <= sign_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
            product_q  <= product_d;
        end
    end

    assign bus.valid    = valid_q;
    assign bus.ready    = ready_q;
    assign bus.overflow = overflow_q;
    assign bus.product  = product_q;
    assign dbg_state    = state_q;
    assign dbg_cnt      = cnt_q;
endmodule

// File: tb/tb_fixed_multiplier.sv
// Self-checking bench for fixed_multiplier (Q3.12): directed cases, handshake corners, random ops.
module tb_fixed_multiplier;
    import fixed_pkg::*;

    logic       clk;
    logic       reset;
    mul_state_t dbg_state;
    logic [3:0] dbg_cnt;
    int         n_checks;
    int         n_fail;

    fixed_multiplier_if #(.WIDTH(16)) bus ();

    fixed_multiplier #(.WIDTH(16), .Q_BITS(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer product, round half away from zero, then range check.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] p, output logic ov);
        longint pa, mag, res;
        logic   s;
        pa  = longint'($signed(a)) * longint'($signed(b));
        s   = a[15] ^ b[15];
        if (pa < 0) pa = -pa;
        mag = (pa + 2048) / 4096;
        ov  = s ? (mag > 32768) : (mag > 32767);
        res = s ? -mag : mag;
        p   = res[15:0];
`ifdef FIXED_MUL_SATURATE_EN
        if (ov) p = s ? 16'h8000 : 16'h7FFF;
`endif
    endtask

    // Issue one op from idle and wait for valid; lat counts edges after the accepting edge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] p, output logic ov, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = a;
        bus.multiplier = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.multiplicand = 16'($urandom);
        bus.multiplier = 16'($urandom);
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (bus.valid === 1'b1) break;
            if (lat > 100) break;
        end
        p  = bus.product;
        ov = bus.overflow;
    endtask

    task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p, ep;
        logic        ov, eov;
        int          lat;
        model(a, b, ep, eov);
        do_op(a, b, p, ov, lat);
        n_checks++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected 17", name, lat);
        end
        n_checks++;
        if (p !== ep) begin
            n_fail++;
            $display("FAIL %s product %h*%h: got %h expected %h", name, a, b, p, ep);
        end
        n_checks++;
        if (ov !== eov) begin
            n_fail++;
            $display("FAIL %s overflow %h*%h: got %b expected %b", name, a, b, ov, eov);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid width: got %b expected 0", name, bus.valid);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.valid, bus.ready, bus.overflow, bus.product} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset outputs: got v%b r%b o%b p%h expected v0 r1 o0 p0000",
                     bus.valid, bus.ready, bus.overflow, bus.product);
        end
        n_checks++;
        if (dbg_state !== MUL_IDLE || dbg_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset state: got %0d cnt %0d expected IDLE cnt 0", dbg_state, dbg_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        check_op("basic_1p5x2", 16'h1800, 16'h2000);
        check_op("neg_a", 16'hE800, 16'h2000);
        check_op("neg_both", 16'hE800, 16'hE000);
        check_op("ovf_pos", 16'h4000, 16'h4000);
        check_op("ovf_neg", 16'hC000, 16'h4000);
        check_op("min_x1", 16'h8000, 16'h1000);
        check_op("min_xm1", 16'h8000, 16'hF000);
        check_op("round_up", 16'h0001, 16'h0800);
        check_op("round_neg", 16'hFFFF, 16'h0800);
        check_op("round_down", 16'h0001, 16'h07FF);
        check_op("zero", 16'h0000, 16'h7FFF);
        check_op("neg_zero", 16'hFFFF, 16'h0000);
    endtask

    task automatic test_ignore_start();
        logic [15:0] ep;
        logic        eov;
        int          lat;
        model(16'h1800, 16'h2000, ep, eov);
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 16'h1800;
        bus.multiplier = 16'h2000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready: got %b expected 0", bus.ready);
        end
        bus.start = 1'b1;
        bus.multiplicand = 16'h4000;
        bus.multiplier = 16'h7000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 5;
        while (bus.valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 17 || bus.product !== ep || bus.overflow !== eov) begin
            n_fail++;
            $display("FAIL ignore_start: got lat %0d p %h o %b expected lat 17 p %h o %b",
                     lat, bus.product, bus.overflow, ep, eov);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 16'h1800;
        bus.multiplier = 16'h2000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || dbg_state !== MUL_IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_run: got r%b v%b state %0d expected r1 v0 IDLE",
                     bus.ready, bus.valid, dbg_state);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_valid: got %0d pulses expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p1, ep1, ep2, a2, b2;
        logic        ov1, eov1, eov2;
        int          lat, held_bad;
        a2 = 16'($urandom);
        b2 = 16'($urandom);
        model(16'hE800, 16'hE000, ep1, eov1);
        model(a2, b2, ep2, eov2);
        do_op(16'hE800, 16'hE000, p1, ov1, lat);
        n_checks++;
        if (p1 !== ep1 || lat !== 17) begin
            n_fail++;
            $display("FAIL b2b_first: got p %h lat %0d expected p %h lat 17", p1, lat, ep1);
        end
        // Still in the valid cycle: ready is high, so this start is taken on the next edge.
        bus.start = 1'b1;
        bus.multiplicand = a2;
        bus.multiplier = b2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_checks++;
        if (bus.valid !== 1'b0 || bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got v%b r%b expected v0 r0", bus.valid, bus.ready);
        end
        lat = 0;
        held_bad = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.valid === 1'b1) break;
            if (bus.product !== ep1) held_bad++;
        end
        n_checks++;
        if (held_bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_hold: got %0d changed cycles expected 0", held_bad);
        end
        n_checks++;
        if (lat !== 17 || bus.product !== ep2 || bus.overflow !== eov2) begin
            n_fail++;
            $display("FAIL b2b_second %h*%h: got lat %0d p %h o %b expected lat 17 p %h o %b",
                     a2, b2, lat, bus.product, bus.overflow, ep2, eov2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = 16'($urandom); b = 16'($urandom); end
                1: begin a = 16'($urandom_range(0, 16'h1FFF)); b = 16'($urandom_range(0, 16'h1FFF)); end
                2: begin a = 16'h8000; b = 16'($urandom); end
                default: begin a = 16'($urandom_range(0, 16'h0FFF)) | 16'hF000; b = 16'($urandom_range(0, 16'h0FFF)); end
            endcase
            check_op("random", a, b);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
